// File: rtl/sram_pkg.sv
// sram_pkg: shared definitions for the AXI-lite-style SRAM slave.
//   RESP_OKAY / RESP_SLVERR : response codes driven on rresp / bresp
//   r_state_e               : read channel FSM states
//   w_state_e               : write channel FSM states
package sram_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_RESP
  } r_state_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_ADDR,
    W_DATA,
    W_RESP
  } w_state_e;

endpackage

// File: rtl/sram_array.sv
// sram_array: DEPTH x DATA_W storage, one synchronous read port and one
// byte-enabled write port.
//   clk, reset_n           : clock / async active-low reset (read register only)
//   rd_en, rd_idx, rd_data : read sampled on the edge rd_en is high; rd_data
//                            holds until the next rd_en
//   wr_en, wr_idx, wr_data, wr_strb : byte-masked write
// A read and write of the same word on one edge returns the old contents.
// Storage itself is not reset.
module sram_array #(
  parameter  int DATA_W = 64,
  parameter  int DEPTH  = 1024,
  localparam int STRB_W = DATA_W / 8,
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rd_en,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [STRB_W-1:0] wr_strb
);

  logic [STRB_W-1:0][7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wr_strb[b]) mem[wr_idx][b] <= wr_data[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_idx];
  end

endmodule

// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI-lite-style memory slave with independent read and
// write channels, configurable read latency and SLVERR on out-of-range access.
//   clk, reset_n                       : clock / async active-low reset
//   ar_valid/ar_ready, araddr          : read address
//   r_valid/r_ready, rdata, rresp      : read data / response
//   aw_valid/aw_ready, awaddr          : write address
//   w_valid/w_ready, wdata, wstrb      : write data / byte enables
//   bvalid/bready, bresp               : write response
// Build option SRAM_DPI_EN: replaces the internal array with pmem_read /
// pmem_write calls on the full address; no range check, always OKAY.
// Ready outputs decode registered state only; everything else is registered.
module axi_sram_slave
  import sram_pkg::*;
#(
  parameter int                ADDR_W = 64,
  parameter int                DATA_W = 64,
  parameter int                DEPTH  = 1024,
  parameter logic [ADDR_W-1:0] BASE   = ADDR_W'(64'h8000_0000),
  parameter int                RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ar_valid,
  output logic                  ar_ready,
  input  logic [ADDR_W-1:0]     araddr,
  output logic                  r_valid,
  input  logic                  r_ready,
  output logic [DATA_W-1:0]     rdata,
  output logic [1:0]            rresp,
  input  logic                  aw_valid,
  output logic                  aw_ready,
  input  logic [ADDR_W-1:0]     awaddr,
  input  logic                  w_valid,
  output logic                  w_ready,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wstrb,
  output logic                  bvalid,
  input  logic                  bready,
  output logic [1:0]            bresp
);

  localparam int         STRB_W   = DATA_W / 8;
  localparam int         OFF_W    = $clog2(STRB_W);
  localparam int         IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // R_WAIT lasts RD_LAT-1 cycles: load RD_LAT-2 and leave when it hits zero.
  localparam logic [2:0] CNT_INIT = (RD_LAT > 1) ? 3'(RD_LAT - 2) : 3'd0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
  } wr_req_t;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
`ifdef SRAM_DPI_EN
    in_range = 1'b1;
`else
    in_range = (a >= BASE) && (((a - BASE) >> OFF_W) < ADDR_W'(DEPTH));
`endif
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
    word_idx = IDX_W'((a - BASE) >> OFF_W);
  endfunction

  // Held low through reset, high from the first edge after release, so the
  // readies come up one edge after reset_n rises.
  logic live;

  // ---------------- read channel ----------------
  r_state_e          r_state, r_next;
  logic [2:0]        r_cnt;
  logic              rd_err;
  logic [DATA_W-1:0] rd_word;
  logic              ar_hs;

  assign ar_ready = live && (r_state == R_IDLE);
  assign ar_hs    = ar_valid && ar_ready;

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_next = (RD_LAT > 1) ? R_WAIT : R_RESP;
      R_WAIT:  if (r_cnt == 3'd0) r_next = R_RESP;
      R_RESP:  if (r_ready) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      live    <= 1'b0;
      r_state <= R_IDLE;
      r_valid <= 1'b0;
      r_cnt   <= 3'd0;
      rd_err  <= 1'b0;
    end else begin
      live    <= 1'b1;
      r_state <= r_next;
      r_valid <= (r_next == R_RESP);
      if (ar_hs) begin
        r_cnt  <= CNT_INIT;
        rd_err <= !in_range(araddr);
      end else if (r_state == R_WAIT && r_cnt != 3'd0) begin
        r_cnt <= r_cnt - 3'd1;
      end
    end
  end

  // rd_word and rd_err only change on an AR handshake, so both stay frozen
  // while a response is waiting on r_ready.
  assign rdata = rd_err ? '0 : rd_word;
  assign rresp = rd_err ? RESP_SLVERR : RESP_OKAY;

  // ---------------- write channel ----------------
  w_state_e w_state, w_next;
  wr_req_t  hold;    // half of a write that arrived first
  wr_req_t  cmt;     // what gets committed this edge
  logic     commit;
  logic     aw_hs, w_hs;

  assign aw_ready = live && (w_state == W_IDLE || w_state == W_DATA);
  assign w_ready  = live && (w_state == W_IDLE || w_state == W_ADDR);
  assign aw_hs    = aw_valid && aw_ready;
  assign w_hs     = w_valid && w_ready;

  always_comb begin
    w_next   = w_state;
    commit   = 1'b0;
    cmt.addr = awaddr;
    cmt.data = wdata;
    cmt.strb = wstrb;
    case (w_state)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          commit = 1'b1;
          w_next = W_RESP;
        end else if (aw_hs) begin
          w_next = W_ADDR;
        end else if (w_hs) begin
          w_next = W_DATA;
        end
      end
      W_ADDR: begin
        cmt.addr = hold.addr;
        if (w_hs) begin
          commit = 1'b1;
          w_next = W_RESP;
        end
      end
      W_DATA: begin
        cmt.data = hold.data;
        cmt.strb = hold.strb;
        if (aw_hs) begin
          commit = 1'b1;
          w_next = W_RESP;
        end
      end
      W_RESP:  if (bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w_state <= W_IDLE;
      bvalid  <= 1'b0;
      bresp   <= RESP_OKAY;
      hold    <= '0;
    end else begin
      w_state <= w_next;
      bvalid  <= (w_next == W_RESP);
      if (w_state == W_IDLE && aw_hs) hold.addr <= awaddr;
      if (w_state == W_IDLE && w_hs) begin
        hold.data <= wdata;
        hold.strb <= wstrb;
      end
      if (commit) bresp <= in_range(cmt.addr) ? RESP_OKAY : RESP_SLVERR;
    end
  end

  // ---------------- storage ----------------
`ifdef SRAM_DPI_EN
  logic [63:0] pmem [longint unsigned];

  function automatic void pmem_read(input longint unsigned addr,
                                    output longint unsigned data);
    data = pmem.exists(addr >> 3) ? pmem[addr >> 3] : 64'd0;
  endfunction

  function automatic void pmem_write(input longint unsigned addr,
                                     input longint unsigned data,
                                     input byte unsigned strb);
    logic [63:0] w;
    w = pmem.exists(addr >> 3) ? pmem[addr >> 3] : 64'd0;
    for (int b = 0; b < 8; b++) begin
      if (strb[b]) w[b*8 +: 8] = data[b*8 +: 8];
    end
    pmem[addr >> 3] = w;
  endfunction

  // Read is issued before write so a same-edge collision sees old data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_word <= '0;
    end else begin
      if (ar_hs) begin
        longint unsigned d;
        pmem_read(64'(araddr), d);
        rd_word <= DATA_W'(d);
      end
      if (commit) pmem_write(64'(cmt.addr), 64'(cmt.data), 8'(cmt.strb));
    end
  end
`else
  sram_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk     (clk),
    .reset_n (reset_n),
    .rd_en   (ar_hs && in_range(araddr)),
    .rd_idx  (word_idx(araddr)),
    .rd_data (rd_word),
    .wr_en   (commit && in_range(cmt.addr)),
    .wr_idx  (word_idx(cmt.addr)),
    .wr_data (cmt.data),
    .wr_strb (cmt.strb)
  );
`endif

endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave: table-driven vectors plus hand sequences for the
// out-of-order write, backpressure and reset corner cases. Expected responses
// are queued when a transaction is issued and popped by channel monitors.
module tb_axi_sram_slave;

  localparam int          ADDR_W = 64;
  localparam int          DATA_W = 64;
  localparam int          DEPTH  = 1024;
  localparam int          RD_LAT = 2;
  localparam logic [63:0] BASE   = 64'h8000_0000;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              ar_valid, ar_ready, r_valid, r_ready;
  logic [ADDR_W-1:0] araddr, awaddr;
  logic [DATA_W-1:0] rdata, wdata;
  logic [1:0]        rresp, bresp;
  logic              aw_valid, aw_ready, w_valid, w_ready, bvalid, bready;
  logic [7:0]        wstrb;

  axi_sram_slave #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .BASE(BASE), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .araddr(araddr),
    .r_valid(r_valid), .r_ready(r_ready), .rdata(rdata), .rresp(rresp),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .awaddr(awaddr),
    .w_valid(w_valid), .w_ready(w_ready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [63:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
    logic [63:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  typedef struct {
    logic [63:0] data;
    logic [1:0]  resp;
  } rexp_t;

  rexp_t      exp_r[$];
  logic [1:0] exp_b[$];
  vec_t       vt[$];
  rexp_t      re;
  logic [1:0] be;
  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Channel monitors: a transfer is seen once, at the negedge before its edge.
  always @(negedge clk) begin
    if (reset_n && r_valid && r_ready) begin
      if (exp_r.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL r_unexpected: got rdata %h with no read outstanding", rdata);
      end else begin
        re = exp_r.pop_front();
        chk("rdata", rdata, re.data);
        chk("rresp", 64'(rresp), 64'(re.resp));
      end
    end
    if (reset_n && bvalid && bready) begin
      if (exp_b.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL b_unexpected: got bresp %b with no write outstanding", bresp);
      end else begin
        be = exp_b.pop_front();
        chk("bresp", 64'(bresp), 64'(be));
      end
    end
  end

  task automatic do_read(input logic [63:0] a, input logic [63:0] d, input logic [1:0] rsp);
    int n, lat;
    araddr   = a;
    ar_valid = 1'b1;
    exp_r.push_back('{d, rsp});
    n = 0;
    while (!ar_ready && n < 50) begin step(); n++; end
    chk("ar_ready_wait", 64'(ar_ready), 64'd1);
    step();                       // AR handshake edge
    ar_valid = 1'b0;
    lat = 1;
    while (!r_valid && lat < 50) begin step(); lat++; end
    chk("r_latency", 64'(lat), 64'(RD_LAT));
    n = 0;
    while (r_valid && n < 50) begin step(); n++; end
    chk("r_done", 64'(r_valid), 64'd0);
  endtask

  task automatic do_write(input logic [63:0] a, input logic [63:0] d,
                          input logic [7:0] s, input logic [1:0] rsp);
    int n;
    awaddr   = a;
    wdata    = d;
    wstrb    = s;
    aw_valid = 1'b1;
    w_valid  = 1'b1;
    exp_b.push_back(rsp);
    n = 0;
    while (!(aw_ready && w_ready) && n < 50) begin step(); n++; end
    step();                       // commit edge
    aw_valid = 1'b0;
    w_valid  = 1'b0;
    chk("b_latency", 64'(bvalid), 64'd1);
    n = 0;
    while (bvalid && n < 50) begin step(); n++; end
    chk("b_done", 64'(bvalid), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    logic bseen;
    ar_valid = 0; araddr = '0; r_ready = 1'b1;
    aw_valid = 0; awaddr = '0; w_valid = 0; wdata = '0; wstrb = '0; bready = 1'b1;

    vt.push_back('{1'b1, 64'h8000_0008, 64'h1122_3344_5566_7788, 8'hFF, 64'h0, 2'b00});
    vt.push_back('{1'b0, 64'h8000_0008, 64'h0, 8'h00, 64'h1122_3344_5566_7788, 2'b00});
    vt.push_back('{1'b1, 64'h8000_0008, 64'hAAAA_AAAA_BBBB_BBBB, 8'h0F, 64'h0, 2'b00});
    vt.push_back('{1'b0, 64'h8000_0008, 64'h0, 8'h00, 64'h1122_3344_BBBB_BBBB, 2'b00});
    vt.push_back('{1'b1, 64'h8000_0000, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'h0, 2'b00});
    vt.push_back('{1'b0, 64'h8000_2000, 64'h0, 8'h00, 64'h0, 2'b10});
    vt.push_back('{1'b1, 64'h7FFF_FFF8, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, 64'h0, 2'b10});
    vt.push_back('{1'b0, 64'h8000_0000, 64'h0, 8'h00, 64'h0123_4567_89AB_CDEF, 2'b00});
    vt.push_back('{1'b1, 64'h8000_1FF8, 64'hCAFE_F00D_CAFE_F00D, 8'hFF, 64'h0, 2'b00});
    vt.push_back('{1'b1, 64'h8000_1FFF, 64'h1111_1111_2222_2222, 8'h0F, 64'h0, 2'b00});
    vt.push_back('{1'b0, 64'h8000_1FF8, 64'h0, 8'h00, 64'hCAFE_F00D_2222_2222, 2'b00});
    vt.push_back('{1'b1, 64'h7FFF_FFF8, 64'h5555_5555_5555_5555, 8'hFF, 64'h0, 2'b10});
    vt.push_back('{1'b0, 64'h8000_1FF8, 64'h0, 8'h00, 64'hCAFE_F00D_2222_2222, 2'b00});
    vt.push_back('{1'b1, 64'h8000_2000, 64'h9999_9999_9999_9999, 8'hFF, 64'h0, 2'b10});
    vt.push_back('{1'b0, 64'h8000_2007, 64'h0, 8'h00, 64'h0, 2'b10});
    vt.push_back('{1'b0, 64'h0000_0000, 64'h0, 8'h00, 64'h0, 2'b10});
    vt.push_back('{1'b0, 64'h1_8000_0008, 64'h0, 8'h00, 64'h0, 2'b10});
    vt.push_back('{1'b0, 64'h8000_0005, 64'h0, 8'h00, 64'h0123_4567_89AB_CDEF, 2'b00});
    vt.push_back('{1'b1, 64'h8000_0004, 64'hFFEE_DDCC_BBAA_9988, 8'h81, 64'h0, 2'b00});
    vt.push_back('{1'b0, 64'h8000_0000, 64'h0, 8'h00, 64'hFF23_4567_89AB_CD88, 2'b00});

    // ---- reset values ----
    step(3);
    chk("rst_r_valid", 64'(r_valid), 64'd0);
    chk("rst_bvalid", 64'(bvalid), 64'd0);
    chk("rst_rdata", rdata, 64'd0);
    chk("rst_rresp", 64'(rresp), 64'd0);
    chk("rst_bresp", 64'(bresp), 64'd0);
    chk("rst_ar_ready", 64'(ar_ready), 64'd0);
    chk("rst_aw_ready", 64'(aw_ready), 64'd0);
    chk("rst_w_ready", 64'(w_ready), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("ready_before_edge", 64'(ar_ready), 64'd0);
    step();
    chk("ar_ready_up", 64'(ar_ready), 64'd1);
    chk("aw_ready_up", 64'(aw_ready), 64'd1);
    chk("w_ready_up", 64'(w_ready), 64'd1);

    // ---- vector table ----
    foreach (vt[i]) begin
      if (vt[i].wr) do_write(vt[i].addr, vt[i].data, vt[i].strb, vt[i].exp_resp);
      else          do_read(vt[i].addr, vt[i].exp_data, vt[i].exp_resp);
    end

    // ---- W three cycles ahead of AW ----
    wdata = 64'h5A5A_0F0F_3C3C_9696; wstrb = 8'hFF; w_valid = 1'b1;
    exp_b.push_back(2'b00);
    step();
    w_valid = 1'b0;
    chk("w_first_w_ready_drop", 64'(w_ready), 64'd0);
    chk("w_first_aw_ready", 64'(aw_ready), 64'd1);
    step();
    chk("w_first_aw_ready_2", 64'(aw_ready), 64'd1);
    chk("w_first_no_b", 64'(bvalid), 64'd0);
    step();
    chk("w_first_aw_ready_3", 64'(aw_ready), 64'd1);
    awaddr = 64'h8000_0010; aw_valid = 1'b1;
    step();
    aw_valid = 1'b0;
    chk("w_first_b_after_aw", 64'(bvalid), 64'd1);
    n = 0;
    while (bvalid && n < 50) begin step(); n++; end
    do_read(64'h8000_0010, 64'h5A5A_0F0F_3C3C_9696, 2'b00);

    // ---- AW two cycles ahead of W ----
    awaddr = 64'h8000_0020; aw_valid = 1'b1;
    exp_b.push_back(2'b00);
    step();
    aw_valid = 1'b0;
    chk("aw_first_aw_ready_drop", 64'(aw_ready), 64'd0);
    chk("aw_first_w_ready", 64'(w_ready), 64'd1);
    step();
    wdata = 64'h0BAD_F00D_1234_5678; wstrb = 8'hFF; w_valid = 1'b1;
    step();
    w_valid = 1'b0;
    chk("aw_first_b_after_w", 64'(bvalid), 64'd1);
    n = 0;
    while (bvalid && n < 50) begin step(); n++; end
    do_read(64'h8000_0020, 64'h0BAD_F00D_1234_5678, 2'b00);

    // ---- r_ready held low, write proceeds meanwhile ----
    r_ready = 1'b0;
    araddr = 64'h8000_0008; ar_valid = 1'b1;
    exp_r.push_back('{64'h1122_3344_BBBB_BBBB, 2'b00});
    step();
    ar_valid = 1'b0;
    n = 0;
    while (!r_valid && n < 50) begin step(); n++; end
    awaddr = 64'h8000_0018; wdata = 64'h7777_6666_5555_4444; wstrb = 8'hFF;
    aw_valid = 1'b1; w_valid = 1'b1;
    exp_b.push_back(2'b00);
    bseen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_r_valid", 64'(r_valid), 64'd1);
      chk("stall_rdata", rdata, 64'h1122_3344_BBBB_BBBB);
      chk("stall_rresp", 64'(rresp), 64'd0);
      chk("stall_ar_ready", 64'(ar_ready), 64'd0);
      if (bvalid) bseen = 1'b1;
      step();
      if (i == 0) begin aw_valid = 1'b0; w_valid = 1'b0; end
    end
    chk("stall_b_independent", 64'(bseen), 64'd1);
    r_ready = 1'b1;
    step();
    chk("stall_release", 64'(r_valid), 64'd0);
    do_read(64'h8000_0018, 64'h7777_6666_5555_4444, 2'b00);

    // ---- bready held low on an error response ----
    bready = 1'b0;
    awaddr = 64'h7FFF_FFF8; wdata = 64'h1; wstrb = 8'hFF;
    aw_valid = 1'b1; w_valid = 1'b1;
    exp_b.push_back(2'b10);
    step();
    aw_valid = 1'b0; w_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bstall_bvalid", 64'(bvalid), 64'd1);
      chk("bstall_bresp", 64'(bresp), 64'd2);
      chk("bstall_aw_ready", 64'(aw_ready), 64'd0);
      chk("bstall_w_ready", 64'(w_ready), 64'd0);
      step();
    end
    bready = 1'b1;
    step();
    chk("bstall_release", 64'(bvalid), 64'd0);

    // ---- reset while in R_WAIT ----
    araddr = 64'h8000_0008; ar_valid = 1'b1;
    step();
    ar_valid = 1'b0;
    chk("rwait_r_valid", 64'(r_valid), 64'd0);
    #2 reset_n = 1'b0;
    #1;
    chk("rwait_rst_r_valid", 64'(r_valid), 64'd0);
    chk("rwait_rst_ar_ready", 64'(ar_ready), 64'd0);
    chk("rwait_rst_rdata", rdata, 64'd0);
    chk("rwait_rst_w_ready", 64'(w_ready), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    step();
    chk("rwait_after_ar_ready", 64'(ar_ready), 64'd1);
    do_read(64'h8000_0008, 64'h1122_3344_BBBB_BBBB, 2'b00);

    // ---- reset with r_valid high and a half-written AW pending ----
    r_ready = 1'b0;
    araddr = 64'h8000_0008; ar_valid = 1'b1;
    step();
    ar_valid = 1'b0;
    n = 0;
    while (!r_valid && n < 50) begin step(); n++; end
    awaddr = 64'h8000_0028; aw_valid = 1'b1;
    step();
    aw_valid = 1'b0;
    chk("half_aw_w_ready", 64'(w_ready), 64'd1);
    chk("half_r_valid", 64'(r_valid), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("rresp_rst_r_valid", 64'(r_valid), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    r_ready = 1'b1;
    step();
    chk("rst2_ar_ready", 64'(ar_ready), 64'd1);
    chk("rst2_aw_ready", 64'(aw_ready), 64'd1);
    chk("rst2_w_ready", 64'(w_ready), 64'd1);
    wdata = 64'h3141_5926_5358_9793; wstrb = 8'hFF; w_valid = 1'b1;
    exp_b.push_back(2'b00);
    step();
    w_valid = 1'b0;
    chk("half_write_discarded", 64'(bvalid), 64'd0);
    awaddr = 64'h8000_0028; aw_valid = 1'b1;
    step();
    aw_valid = 1'b0;
    chk("rst2_b_after_aw", 64'(bvalid), 64'd1);
    n = 0;
    while (bvalid && n < 50) begin step(); n++; end
    do_read(64'h8000_0028, 64'h3141_5926_5358_9793, 2'b00);
    do_read(64'h8000_0008, 64'h1122_3344_BBBB_BBBB, 2'b00);

    step(4);
    chk("r_queue_drained", 64'(exp_r.size()), 64'd0);
    chk("b_queue_drained", 64'(exp_b.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_sram_slave.md
# axi_sram_slave

Parametrised AXI-lite-style memory slave; successor to the single-FSM SRAM model. Read and write channels run independently, AW and W may arrive in any order, read latency is configurable, and out-of-range accesses return SLVERR. Sits on the NPC simulation bus as the main memory endpoint for the core's instruction and data ports.

## Interface
- ADDR_W, 64, address width
- DATA_W, 64, data width; power of two, at least 32
- DEPTH, 1024, memory depth in DATA_W words
- BASE, 64'h8000_0000, byte address of word 0
- RD_LAT, 1, cycles from AR handshake to r_valid; legal range 1..4
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- ar_valid / ar_ready  in / out  1  read address handshake
- araddr  in  ADDR_W  read byte address
- r_valid / r_ready  out / in  1  read data handshake
- rdata  out  DATA_W  read data
- rresp  out  2  read response
- aw_valid / aw_ready  in / out  1  write address handshake
- awaddr  in  ADDR_W  write byte address
- w_valid / w_ready  in / out  1  write data handshake
- wdata  in  DATA_W  write data
- wstrb  in  DATA_W/8  byte enables
- bvalid / bready  out / in  1  write response handshake
- bresp  out  2  write response

## Operation
- Word index = (addr − BASE) >> log2(DATA_W/8). Low byte-offset bits are ignored.
- An address is in range when addr ≥ BASE and the index < DEPTH. Otherwise the response is SLVERR (2'b10), rdata = 0, and no write occurs. In range gives OKAY (2'b00).
- Read FSM:
  - R_IDLE: ar_ready = 1. On ar_valid, capture the address, sample the memory, and go to R_WAIT (or straight to R_RESP when RD_LAT = 1).
  - R_WAIT: count down RD_LAT−1 cycles, then go to R_RESP.
  - R_RESP: r_valid = 1. On r_ready, return to R_IDLE.
- Write FSM:
  - W_IDLE: aw_ready = w_ready = 1.
    - Both valid: commit and go to W_RESP.
    - AW only: go to W_ADDR.
    - W only: go to W_DATA.
  - W_ADDR: w_ready = 1 only. On w_valid, commit and go to W_RESP.
  - W_DATA: aw_ready = 1 only. On aw_valid, commit and go to W_RESP.
  - W_RESP: bvalid = 1. On bready, return to W_IDLE.
- Commit writes only the bytes whose wstrb bit is set.
- If a read sample and a write commit hit the same word on the same edge, the read returns the pre-write data.
- The read FSM never stalls the write FSM, and the write FSM never stalls the read FSM.

## Timing
- Reset values (while reset_n is low): r_valid = 0, bvalid = 0, rdata = 0, rresp = 0, bresp = 0, ar_ready = aw_ready = w_ready = 0.
- All ready outputs go to 1 on the first rising edge after reset_n is released.
- Memory contents are not reset.
- Asserting reset_n low mid-transaction drops r_valid and bvalid immediately (asynchronous) and discards any pending half-write.
- r_valid rises exactly RD_LAT cycles after the AR handshake edge.
- bvalid rises one cycle after the commit edge.
- While r_valid && !r_ready, rdata and rresp are held stable; the same applies to bresp under bvalid && !bready.
- Peak throughput: one read per RD_LAT+1 cycles; one write per 2 cycles.
- All outputs are registered except the ready signals, which decode the current state only and have no input-to-output combinational path.

## Configuration
- SRAM_DPI_EN defined:
  - Reads and writes call the DPI-C functions pmem_read(addr, data) and pmem_write(addr, data, strb) with the full address at the same sample/commit edges.
  - No range check is done; every response is OKAY.
  - The internal array is not instantiated.
- SRAM_DPI_EN undefined: the internal DEPTH × DATA_W array with range checking is used.

## Structure
- Shared package sram_pkg holds:
  - response constants RESP_OKAY = 2'b00 and RESP_SLVERR = 2'b10
  - read-state and write-state enums
- Sub-module sram_array:
  - DEPTH × DATA_W storage with byte-write enables and synchronous read
  - one read port and one write port
  - replaced by the DPI calls under SRAM_DPI_EN

## Test plan
All scenarios use default parameters with RD_LAT = 2 unless stated otherwise.
- Write 64'h1122_3344_5566_7788 to 0x8000_0008 with wstrb 8'hFF, then read it back -> bresp 00; r_valid exactly 2 cycles after the AR handshake; rdata matches; rresp 00.
- Overwrite the same word with 64'hAAAA_AAAA_BBBB_BBBB and wstrb 8'h0F, then read -> rdata 64'h1122_3344_BBBB_BBBB.
- Drive W 3 cycles before AW -> w_ready drops after the W handshake; aw_ready stays 1; bvalid asserts the cycle after the AW handshake; the data is written correctly.
- Read 0x8000_2000 and write 0x7FFF_FFF8 -> rresp 10 with rdata 0; bresp 10; a readback of 0x8000_0000 is unchanged.
- Hold r_ready low for 5 cycles with r_valid high -> rdata and rresp stable, ar_ready 0; with AW and W valid during those cycles, bvalid asserts independently.
- Pull reset_n low while in R_WAIT -> r_valid goes 0 immediately; after release, ar_ready is 1 and a reread of 0x8000_0008 returns the previously written data.
